fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning the instruction-memory word-address width (64 words).
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port imem_a  output  ADDR_W  word address to instruction memory.
REQ-006 Port imem_rd  input  32  instruction word returned combinationally for imem_a.
REQ-007 Port stall  input  1  hazard stall: hold the PC and the IF/ID register.
REQ-008 Port flush  input  1  squash the IF/ID register.
REQ-009 Port redirect  input  1  a branch or jump is taken this cycle.
REQ-010 Port redirect_pc  input  32  target of the taken branch or jump.
REQ-011 Port pc_f  output  32  current fetch PC.
REQ-012 Port instr_d, pc_d, pcplus4_d  output  32 each  IF/ID contents: instruction, its PC, its PC+4.
REQ-013 Port valid_d  output  1  instr_d holds a real instruction, not a bubble.
REQ-014 Port misalign_err  output  1  sticky flag for a misaligned redirect.
REQ-015 Port fetch_count  output  32  count of valid instructions loaded into IF/ID.

Function
REQ-016 imem_a SHALL equal pc_f[ADDR_W+1:2], combinationally; PCs at or above 4*2^ADDR_W SHALL alias (wrap) modulo the memory size.
REQ-017 The next PC SHALL follow this priority: reset gives RESET_PC; otherwise redirect gives {redirect_pc[31:2],2'b00}; otherwise stall holds pc_f; otherwise pc_f+4.
REQ-018 pc_f+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-019 The IF/ID register SHALL follow this priority: reset; then stall holds all IF/ID fields, even if flush or redirect is also asserted; then flush or redirect loads a bubble (valid_d=0, instr_d=32'h0, pc_d=0, pcplus4_d=0); otherwise it loads instr_d=imem_rd, pc_d=pc_f, pcplus4_d=pc_f+4, and valid_d=1.
REQ-020 Fetch-to-decode latency SHALL be exactly one cycle: the word addressed by pc_f in cycle N SHALL appear on instr_d in cycle N+1.
REQ-021 When redirect=1 and redirect_pc[1:0]!=0 are sampled at an edge, misalign_err SHALL set to 1 and remain set until reset.
REQ-022 fetch_count SHALL increment by 1 on each edge where IF/ID loads with valid_d=1, SHALL wrap from 32'hFFFF_FFFF to 0, and SHALL NOT change on stall, flush or bubble edges.
REQ-023 Asserting stall continuously SHALL freeze pc_f, imem_a and all IF/ID outputs indefinitely; no instruction SHALL be lost or duplicated.

Reset
REQ-024 At an edge with reset=1, regardless of all other inputs, the block SHALL set pc_f=RESET_PC, instr_d=0, pc_d=0, pcplus4_d=0, valid_d=0, misalign_err=0 and fetch_count=0.
REQ-025 Reset asserted mid-operation SHALL discard any pending redirect or stall effect; on the first edge after reset deasserts, IF/ID SHALL load the word at RESET_PC with valid_d=1.

Structure
REQ-026 Package fetch_pkg SHALL hold: the default value of RESET_PC, the constant NOP_INSTR=32'h0, and a packed struct typedef ifid_t {valid, instr, pc, pcplus4}.
REQ-027 The IF/ID register SHALL be a single sub-module ifid_reg (parameterised on ifid_t) with enable and synchronous clear; the PC register and counters stay inline.

Verification
REQ-028 Straight-line fetch: reset, then 4 free cycles -> pc_f sequence 0,4,8,C; instr_d is the memory words 0..2 in order; fetch_count=3 at the fourth cycle.
REQ-029 Stall: assert stall for 3 cycles with pc_f=8 -> pc_f, imem_a=2 and instr_d stay constant; fetch_count does not change; after release, pc_f=C.
REQ-030 Redirect: redirect=1, redirect_pc=32'h0000_0040 with pc_f=0x10 -> next cycle pc_f=0x40, imem_a=16, valid_d=0; the following cycle pc_d=0x40 and valid_d=1.
REQ-031 Misaligned redirect combined with stall: redirect_pc=32'h0000_0022 and stall=1 -> pc_f=0x20, IF/ID held, misalign_err=1 and stays 1 until reset.
REQ-032 Wrap and mid-operation reset: pc_f=0xFC -> imem_a=63, then pc_f=0x100 gives imem_a=0; assert reset while redirect=1 -> pc_f=RESET_PC and all outputs return to their reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   RESET_PC_DEFAULT : default PC loaded on reset
//   NOP_INSTR        : instruction word placed in IF/ID for a bubble
//   ifid_t           : packed IF/ID pipeline register contents
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with enable and synchronous clear.
//   clk   : rising-edge clock
//   i_en  : load i_d on this edge
//   i_clr : synchronous clear to all-zero, dominates i_en
//   i_d   : next contents
//   o_q   : registered contents
module ifid_reg
    import fetch_pkg::*;
#(
    parameter type T = ifid_t
) (
    input  logic clk,
    input  logic i_en,
    input  logic i_clr,
    input  T     i_d,
    output T     o_q
);

    T r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and IF/ID register of a 5-stage pipeline.
//   clk, reset          : clock, synchronous active-high reset
//   imem_a / imem_rd    : word address to / combinational data from imem
//   stall               : hold PC and IF/ID
//   flush               : squash IF/ID
//   redirect/redirect_pc: taken branch/jump and its target
//   pc_f                : current fetch PC
//   instr_d, pc_d, pcplus4_d, valid_d : IF/ID contents
//   misalign_err        : sticky, set by a redirect to a non-word address
//   fetch_count         : number of valid instructions loaded into IF/ID
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_a,
    input  logic [31:0]       imem_rd,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       pc_f,
    output logic [31:0]       instr_d,
    output logic [31:0]       pc_d,
    output logic [31:0]       pcplus4_d,
    output logic              valid_d,
    output logic              misalign_err,
    output logic [31:0]       fetch_count
);

    logic [31:0] r_pc;
    logic        r_misalign;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic        w_squash;
    logic        w_load_valid;
    ifid_t       w_ifid_d;
    ifid_t       w_ifid_q;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_squash     = flush | redirect;
    // A real instruction enters IF/ID only when not held and not squashed.
    assign w_load_valid = ~stall & ~w_squash;

    // PC register: redirect beats stall, so a taken branch still steers the PC
    // while decode is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_load_valid) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Bubble travels through the data path; the register's clear is reset only,
    // so stall (enable low) naturally outranks flush/redirect.
    always_comb begin
        w_ifid_d = '0;
        if (w_squash) begin
            w_ifid_d.valid   = 1'b0;
            w_ifid_d.instr   = NOP_INSTR;
            w_ifid_d.pc      = '0;
            w_ifid_d.pcplus4 = '0;
        end else begin
            w_ifid_d.valid   = 1'b1;
            w_ifid_d.instr   = imem_rd;
            w_ifid_d.pc      = r_pc;
            w_ifid_d.pcplus4 = w_pc_plus4;
        end
    end

    ifid_reg #(
        .T (ifid_t)
    ) u_ifid_reg (
        .clk   (clk),
        .i_en  (~stall),
        .i_clr (reset),
        .i_d   (w_ifid_d),
        .o_q   (w_ifid_q)
    );

    assign imem_a       = r_pc[ADDR_W+1:2];
    assign pc_f         = r_pc;
    assign instr_d      = w_ifid_q.instr;
    assign pc_d         = w_ifid_q.pc;
    assign pcplus4_d    = w_ifid_q.pcplus4;
    assign valid_d      = w_ifid_q.valid;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    end
    assign imem_rd = mem[imem_a];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_a       (imem_a),
        .imem_rd      (imem_rd),
        .stall        (stall),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc_f         (pc_f),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pcplus4_d    (pcplus4_d),
        .valid_d      (valid_d),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    // One directed vector: inputs for an edge and the hand-computed state after it.
    // w is the memory word index expected on instr_d, or -1 for a zero word.
    typedef struct {
        logic        rst, stl, fl, rd;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [5:0]  a;
        logic        v;
        int          w;
        logic [31:0] pcd, p4, fc;
        logic        me;
    } row_t;

    row_t rows[$];
    row_t exp_q[$];

    function automatic row_t mk(logic rst, logic stl, logic fl, logic rd, logic [31:0] rpc,
                                logic [31:0] pc, logic [5:0] a, logic v, int w,
                                logic [31:0] pcd, logic [31:0] p4, logic [31:0] fc, logic me);
        row_t r;
        r.rst = rst; r.stl = stl; r.fl = fl; r.rd = rd; r.rpc = rpc;
        r.pc = pc; r.a = a; r.v = v; r.w = w; r.pcd = pcd; r.p4 = p4; r.fc = fc; r.me = me;
        return r;
    endfunction

    task automatic chk(input int r, input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL row%0d %s: got %h expected %h", r, name, got, want);
        end
    endtask

    // Monitor: every edge that had a vector pending is checked at the following negedge.
    initial begin
        int   row_idx;
        int   pend;
        row_t e;
        logic [31:0] wi;
        row_idx = 0;
        forever begin
            @(posedge clk);
            pend = exp_q.size();
            @(negedge clk);
            if (pend > 0) begin
                e  = exp_q.pop_front();
                wi = (e.w < 0) ? 32'h0 : 32'hC0DE_0000 + 32'(e.w);
                chk(row_idx, "pc_f",         pc_f,                 e.pc);
                chk(row_idx, "imem_a",       {26'd0, imem_a},      {26'd0, e.a});
                chk(row_idx, "valid_d",      {31'd0, valid_d},     {31'd0, e.v});
                chk(row_idx, "instr_d",      instr_d,              wi);
                chk(row_idx, "pc_d",         pc_d,                 e.pcd);
                chk(row_idx, "pcplus4_d",    pcplus4_d,            e.p4);
                chk(row_idx, "fetch_count",  fetch_count,          e.fc);
                chk(row_idx, "misalign_err", {31'd0, misalign_err}, {31'd0, e.me});
                row_idx++;
            end
        end
    end

    initial begin
        //            rst stl fl rd  rpc            pc             a   v  w   pc_d           pcplus4_d      fc  me
        rows.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0,         0,  0, -1, 32'h0,         32'h0,         0,  0)); // 0 reset
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h4,         1,  1,  0, 32'h0,         32'h4,         1,  0)); // 1
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h8,         2,  1,  1, 32'h4,         32'h8,         2,  0)); // 2
        rows.push_back(mk(0, 1, 0, 0, 32'h0,         32'h8,         2,  1,  1, 32'h4,         32'h8,         2,  0)); // 3 stall
        rows.push_back(mk(0, 1, 0, 0, 32'h0,         32'h8,         2,  1,  1, 32'h4,         32'h8,         2,  0)); // 4 stall
        rows.push_back(mk(0, 1, 0, 0, 32'h0,         32'h8,         2,  1,  1, 32'h4,         32'h8,         2,  0)); // 5 stall
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'hC,         3,  1,  2, 32'h8,         32'hC,         3,  0)); // 6
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h10,        4,  1,  3, 32'hC,         32'h10,        4,  0)); // 7
        rows.push_back(mk(0, 0, 0, 1, 32'h40,        32'h40,        16, 0, -1, 32'h0,         32'h0,         4,  0)); // 8 redirect
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h44,        17, 1, 16, 32'h40,        32'h44,        5,  0)); // 9
        rows.push_back(mk(0, 0, 1, 0, 32'h0,         32'h48,        18, 0, -1, 32'h0,         32'h0,         5,  0)); // 10 flush
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h4C,        19, 1, 18, 32'h48,        32'h4C,        6,  0)); // 11
        rows.push_back(mk(0, 1, 0, 1, 32'h22,        32'h20,        8,  1, 18, 32'h48,        32'h4C,        6,  1)); // 12 misaligned+stall
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h24,        9,  1,  8, 32'h20,        32'h24,        7,  1)); // 13
        rows.push_back(mk(0, 0, 0, 1, 32'hF8,        32'hF8,        62, 0, -1, 32'h0,         32'h0,         7,  1)); // 14
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'hFC,        63, 1, 62, 32'hF8,        32'hFC,        8,  1)); // 15
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h100,       0,  1, 63, 32'hFC,        32'h100,       9,  1)); // 16 alias
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h104,       1,  1,  0, 32'h100,       32'h104,       10, 1)); // 17
        rows.push_back(mk(1, 1, 1, 1, 32'h40,        32'h0,         0,  0, -1, 32'h0,         32'h0,         0,  0)); // 18 reset wins
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h4,         1,  1,  0, 32'h0,         32'h4,         1,  0)); // 19
        rows.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 63, 0, -1, 32'h0,         32'h0,         1,  0)); // 20
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,         0,  1, 63, 32'hFFFF_FFFC, 32'h0,         2,  0)); // 21 PC wrap
        rows.push_back(mk(0, 1, 1, 0, 32'h0,         32'h0,         0,  1, 63, 32'hFFFF_FFFC, 32'h0,         2,  0)); // 22 stall over flush
        rows.push_back(mk(0, 0, 0, 0, 32'h0,         32'h4,         1,  1,  0, 32'h0,         32'h4,         3,  0)); // 23

        foreach (rows[i]) begin
            if (i != 0) @(negedge clk);
            reset       = rows[i].rst;
            stall       = rows[i].stl;
            flush       = rows[i].fl;
            redirect    = rows[i].rd;
            redirect_pc = rows[i].rpc;
            exp_q.push_back(rows[i]);
        end
        @(negedge clk);
        reset = 1'b0; stall = 1'b1; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
